// File: rtl/spi_rx_buffer_pkg.sv
// Shared constants and types for the SPI receive buffer slice.
// These values mirror the byte width and default depth used across the comms code.
package spi_rx_buffer_pkg;

    localparam int SPI_BYTE_W      = 8;
    localparam int RXBUF_DEPTH_DEF = 8;

    localparam int                   OVR_CNT_W   = 8;
    localparam logic [OVR_CNT_W-1:0] OVR_CNT_MAX = '1;

    typedef logic [SPI_BYTE_W-1:0] spi_byte_t;

endpackage

// File: rtl/spi_rx_buffer_cs_release_detect.sv
// Synchronises an asynchronous active-low chip-select and emits a one-cycle
// pulse when a frame ends (synchronised cs goes 0 -> 1).
module cs_release_detect (
    input  logic clk,
    input  logic reset,
    input  logic cs_in,
    output logic release_pulse
);

    logic       sync1_q;
    logic       sync2_q;
    logic       hist_q;
    logic [1:0] start_q;
    logic       idle_seen_q;
    logic       idle_seen_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            hist_q      <= 1'b1;
            start_q     <= 2'b00;
            idle_seen_q <= 1'b0;
        end else begin
            sync1_q     <= cs_in;
            sync2_q     <= sync1_q;
            hist_q      <= sync2_q;
            start_q     <= {start_q[0], 1'b1};
            idle_seen_q <= idle_seen_d;
        end
    end

    // The reset-value 1s in the synchroniser are not real samples, so a frame
    // already in flight at reset release must not count; only release edges
    // after cs has genuinely been seen idle produce a push.
    assign idle_seen_d   = idle_seen_q | (start_q[1] & sync2_q);
    assign release_pulse = idle_seen_q & sync2_q & ~hist_q;

endmodule

// File: rtl/spi_rx_buffer.sv
// Receive FIFO for bytes captured on an SPI link, pushed once per cs release.
// Define SPI_RXBUF_OVERRUN_CNT_EN to add the saturating ovr_count output.
module spi_rx_buffer
    import spi_rx_buffer_pkg::*;
#(
    parameter int DEPTH = RXBUF_DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs_in,
    input  logic [SPI_BYTE_W-1:0] data_received,
    input  logic                  rd_en,
    input  logic                  clr_overrun,
    output logic [SPI_BYTE_W-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [CW-1:0]         count,
    output logic                  overrun
`ifdef SPI_RXBUF_OVERRUN_CNT_EN
    ,
    output logic [OVR_CNT_W-1:0]  ovr_count
`endif
);

    localparam int AW = $clog2(DEPTH);

    spi_byte_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          overrun_q;
    logic          overrun_d;
    logic          push;
    logic          do_pop;
    logic          do_write;
    logic          drop;

    cs_release_detect u_cs_release_detect (
        .clk           (clk),
        .reset         (reset),
        .cs_in         (cs_in),
        .release_pulse (push)
    );

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign overrun = overrun_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when a pop frees the head slot
    // in the same cycle; a pop request against an empty FIFO is a no-op.
    always_comb begin
        do_pop   = rd_en & ~empty;
        do_write = push & (~full | do_pop);
        drop     = push & full & ~do_pop;

        wr_ptr_d = do_write ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop   ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        if (do_write && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_write && do_pop) begin
            count_d = count_q - CW'(1);
        end

        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= data_received;
        end
    end

`ifdef SPI_RXBUF_OVERRUN_CNT_EN
    logic [OVR_CNT_W-1:0] ovr_count_q;
    logic [OVR_CNT_W-1:0] ovr_count_d;

    // A drop coinciding with a clear restarts the count at one.
    always_comb begin
        ovr_count_d = ovr_count_q;
        if (drop) begin
            if (clr_overrun) begin
                ovr_count_d = OVR_CNT_W'(1);
            end else if (ovr_count_q != OVR_CNT_MAX) begin
                ovr_count_d = ovr_count_q + OVR_CNT_W'(1);
            end
        end else if (clr_overrun) begin
            ovr_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_count_q <= '0;
        end else begin
            ovr_count_q <= ovr_count_d;
        end
    end

    assign ovr_count = ovr_count_q;
`endif

endmodule

// File: doc/spi_rx_buffer.md
SPI_RX_BUFFER -- requirements
Module: spi_rx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter CW, default $clog2(DEPTH)+1, count width.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cs_in  input  1  chip-select of the monitored SPI link (master_cs1/cs2 or slave_cs), active-low, asynchronous to clk.
REQ-006 SHALL have port data_received  input  8  received byte from the SPI stage, stable after the cs release.
REQ-007 SHALL have port rd_en  input  1  pop request, one entry per cycle.
REQ-008 SHALL have port clr_overrun  input  1  clears the overrun flag.
REQ-009 SHALL have port rd_data  output  8  head-of-FIFO byte (show-ahead).
REQ-010 SHALL have port empty  output  1  FIFO empty.
REQ-011 SHALL have port full  output  1  FIFO full.
REQ-012 SHALL have port count  output  CW  number of stored bytes.
REQ-013 SHALL have port overrun  output  1  sticky: a byte was dropped.

Function
REQ-014 SHALL pass cs_in through a 2-flop synchronizer plus one history flop.
REQ-015 SHALL detect frame end as synchronized cs 0->1 (history=0, sync=1); one push per frame.
REQ-016 SHALL push data_received on the clock edge after frame-end detection; latency cs_in rise -> empty deasserted is 4 clk edges max.
REQ-017 SHALL present rd_data = mem[rd_ptr] combinationally when !empty, 8'h00 when empty.
REQ-018 SHALL pop on rd_en && !empty; rd_en while empty is ignored and changes no state.
REQ-019 SHALL wrap wr_ptr and rd_ptr from DEPTH-1 to 0.
REQ-020 SHALL update count +1 on push-only, -1 on pop-only, unchanged on push+pop.
REQ-021 SHALL, on push while full with rd_en=1, accept both (pop then write); no overrun.
REQ-022 SHALL, on push while full with rd_en=0, drop the byte and set overrun.
REQ-023 SHALL, on push while empty with rd_en=1, store the byte; the pop is ignored (no fall-through).
REQ-024 SHALL clear overrun on clr_overrun; set wins if set and clear coincide.
REQ-025 SHALL assert full when count==DEPTH, empty when count==0.

Reset
REQ-026 SHALL, on reset low, force pointers, count=0, overrun=0, empty=1, full=0, rd_data=8'h00 immediately.
REQ-027 SHALL reset synchronizer and history flops to 1 (cs idle) so reset release never produces a push.
REQ-028 SHALL, if reset asserts mid-frame, discard that frame; the next clean 0->1 after release is the first push.
REQ-029 SHALL leave mem contents unreset.

Configuration
REQ-030 SHALL, with SPI_RXBUF_OVERRUN_CNT_EN defined, add output ovr_count[7:0]: +1 per dropped byte, saturating at 255, cleared by clr_overrun (increment wins on coincidence, giving 1).
REQ-031 SHALL, without SPI_RXBUF_OVERRUN_CNT_EN, omit ovr_count port and logic; all other behaviour identical.

Structure
REQ-032 SHALL take SPI_BYTE_W (8) and RXBUF_DEPTH_DEF (8) from the shared commshare.v constants.
REQ-033 SHALL implement sync+edge detect in sub-module cs_release_detect (ports clk, reset, cs_in, release_pulse).
REQ-034 SHALL keep FIFO storage and pointers in spi_rx_buffer itself.

Verification
REQ-035 SHALL check: frame cs_in low 20 cycles, data 8'hA5, cs high -> within 4 edges empty=0, count=1, rd_data=8'hA5; rd_en 1 cycle -> empty=1.
REQ-036 SHALL check: 8 frames 8'h01..8'h08, no reads -> full=1, count=8; 9th frame 8'h09 -> overrun=1, count=8; reads return 01..08 in order.
REQ-037 SHALL check: full, 9th frame edge coincident with rd_en -> overrun=0, count=8, head 8'h02, tail 8'h09.
REQ-038 SHALL check: reset low while cs_in=0, release, cs_in->1 -> no push; next full frame 8'h3C -> count=1.
REQ-039 SHALL check: rd_en while empty -> count=0, pointers unchanged; overrun set and clr_overrun same cycle -> overrun=1.
REQ-040 SHALL check (SPI_RXBUF_OVERRUN_CNT_EN): 260 dropped frames while full -> ovr_count=255; clr_overrun -> 0.
